// File: rtl/if_id_buffer.sv
// IF->ID pipeline buffer: a two-entry FIFO between fetch and decode.
// in_ready comes from registered occupancy only, so fetch never waits on decode
// within the same cycle. An empty buffer presents a NOP at the reset PC.
module if_id_buffer #(
    parameter logic [31:0] NOP_INST = 32'h00000000,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_bus,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] out_bus,
    input  logic        out_ready,
    output logic [1:0]  occupancy,
    output logic [7:0]  flush_count
);

    logic [63:0] r_mem [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [7:0]  r_flush_count;

    logic        w_push;
    logic        w_pop;
    logic        w_flush_hit;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign occupancy = r_count;
    assign flush_count = r_flush_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // A flush only counts when it actually throws work away: stored entries or an offered fetch.
    assign w_flush_hit = flush & ((r_count != 2'd0) | in_valid);

    // Head entry, or a NOP at the reset PC while empty.
    always_comb begin
        out_bus = {NOP_INST, RESET_PC};
        if (r_count != 2'd0) begin
            out_bus = r_mem[r_rd_ptr];
        end
    end

    // Entry storage. It is not reset and not cleared on flush; the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_bus;
        end
    end

    // Pointers and count. Reset outranks flush, and flush discards the cycle's push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of flushes that discarded something. A reset clears it and is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_count <= 8'd0;
        end else if (w_flush_hit && (r_flush_count != 8'hFF)) begin
            r_flush_count <= r_flush_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer. Inputs change 1 ns after a rising edge.
// Outputs are checked 1 ns after a rising edge, once the registers have settled.
module tb_if_id_buffer;

    localparam logic [63:0] EMPTY_BUS = {32'h00000000, 32'hbfc00000};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_bus;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_bus;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic [7:0]  flush_count;

    int checks;
    int errors;

    if_id_buffer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_bus(out_bus),
        .out_ready(out_ready), .occupancy(occupancy), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b0; in_bus = 64'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_bus !== EMPTY_BUS) begin errors++; $display("FAIL reset_out_bus got %h exp %h", out_bus, EMPTY_BUS); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (flush_count !== 8'd0) begin errors++; $display("FAIL reset_flush_count got %0d exp 0", flush_count); end
    endtask

    task automatic test_single_pass();
        idle();
        in_valid = 1'b1; in_bus = {32'h24080001, 32'hbfc00000}; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_bus !== {32'h24080001, 32'hbfc00000}) begin errors++; $display("FAIL single_out_bus got %h exp 24080001bfc00000", out_bus); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
        checks++; if (out_bus !== EMPTY_BUS) begin errors++; $display("FAIL single_empty_bus got %h exp %h", out_bus, EMPTY_BUS); end
        idle();
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1'b1; in_bus = {32'h11111111, 32'hbfc00000};
        step();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d exp 1", occupancy); end
        in_bus = {32'h22222222, 32'hbfc00004};
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got %0d exp 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        in_bus = {32'h33333333, 32'hbfc00008};
        step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_third_dropped got %0d exp 2", occupancy); end
        checks++; if (out_bus !== {32'h11111111, 32'hbfc00000}) begin errors++; $display("FAIL bp_head0 got %h exp 11111111bfc00000", out_bus); end
        out_ready = 1'b1;
        step();
        checks++; if (out_bus !== {32'h22222222, 32'hbfc00004}) begin errors++; $display("FAIL bp_head1 got %h exp 22222222bfc00004", out_bus); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_drain1 got %0d exp 1", occupancy); end
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bp_drain0 got %0d exp 0", occupancy); end
        idle();
    endtask

    task automatic test_full_pop();
        idle();
        in_valid = 1'b1; in_bus = {32'hd0000000, 32'h00001000};
        step();
        in_bus = {32'he0000000, 32'h00001004};
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fp_full got %0d exp 2", occupancy); end
        in_bus = {32'hf0000000, 32'h00001008}; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL fp_occ got %0d exp 1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fp_in_ready got %b exp 1", in_ready); end
        checks++; if (out_bus !== {32'he0000000, 32'h00001004}) begin errors++; $display("FAIL fp_head got %h exp e000000000001004", out_bus); end
        out_ready = 1'b1;
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fp_drain got %0d exp 0", occupancy); end
        idle();
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        idle();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 32'hbfc00100 + 32'(i * 4);
            in_bus = {32'h20000000 + 32'(i), pc};
            step();
            checks++; if (out_bus !== {32'h20000000 + 32'(i), pc}) begin errors++; $display("FAIL stream_%0d got %h exp %h", i, out_bus, {32'h20000000 + 32'(i), pc}); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ_%0d got %0d exp 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_end got %0d exp 0", occupancy); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1'b1; in_bus = {32'haaaa0000, 32'h00002000};
        step();
        in_bus = {32'hbbbb0000, 32'h00002004};
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre got %0d exp 2", occupancy); end
        flush = 1'b1; out_ready = 1'b1; in_bus = {32'hcccc0000, 32'h00002008};
        step();
        idle();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid got %b exp 0", out_valid); end
        checks++; if (out_bus !== EMPTY_BUS) begin errors++; $display("FAIL fl_out_bus got %h exp %h", out_bus, EMPTY_BUS); end
        checks++; if (flush_count !== 8'd1) begin errors++; $display("FAIL fl_count1 got %0d exp 1", flush_count); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_count !== 8'd1) begin errors++; $display("FAIL fl_empty_noinc got %0d exp 1", flush_count); end
        // Pointers restart at slot 0 after a flush.
        in_valid = 1'b1; in_bus = {32'hdddd0000, 32'h0000200c};
        step();
        in_valid = 1'b0;
        checks++; if (out_bus !== {32'hdddd0000, 32'h0000200c}) begin errors++; $display("FAIL fl_repush got %h exp dddd00000000200c", out_bus); end
        // Flush with one entry stored and nothing offered: counts (now 2).
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_count !== 8'd2) begin errors++; $display("FAIL fl_count2 got %0d exp 2", flush_count); end
        in_valid = 1'b1; flush = 1'b1;
        for (int i = 0; i < 252; i++) step();
        checks++; if (flush_count !== 8'hFE) begin errors++; $display("FAIL fl_count254 got %0d exp 254", flush_count); end
        for (int i = 0; i < 46; i++) step();
        checks++; if (flush_count !== 8'hFF) begin errors++; $display("FAIL fl_saturate got %0d exp 255", flush_count); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl_flood_occ got %0d exp 0", occupancy); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        for (int i = 0; i < 5; i++) step();
        flush = 1'b0;
        checks++; if (flush_count !== 8'd5) begin errors++; $display("FAIL rm_count5 got %0d exp 5", flush_count); end
        in_bus = {32'h12340000, 32'h00003000};
        step();
        in_bus = {32'h56780000, 32'h00003004};
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rm_full got %0d exp 2", occupancy); end
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        idle();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rm_occ got %0d exp 0", occupancy); end
        checks++; if (flush_count !== 8'd0) begin errors++; $display("FAIL rm_flush_count got %0d exp 0", flush_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_full_pop();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter: NOP_INST, default 32'h00000000, instruction field presented on out_bus when the buffer is empty.
REQ-002 Parameter: RESET_PC, default 32'hbfc00000, PC field presented on out_bus when the buffer is empty.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  IF stage has a completed fetch (IF_over).
REQ-006 in_bus  input  64  IF->ID bus {inst[63:32], pc[31:0]}.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle (gates next_fetch).
REQ-008 flush  input  1  redirect (exception_triggered | eret_executed | jbr_taken); discard all entries.
REQ-009 out_valid  output  1  head entry available to ID.
REQ-010 out_bus  output  64  head entry {inst, pc}.
REQ-011 out_ready  input  1  ID accepts head entry this cycle.
REQ-012 occupancy  output  2  number of stored entries, 0..2.
REQ-013 flush_count  output  8  count of flushes that discarded at least one entry, saturating.

Function
REQ-014 Storage: 2-entry FIFO of 64-bit entries; 1-bit read pointer, 1-bit write pointer, 2-bit count.
REQ-015 in_ready = (count != 2); depends on registered state only, never combinationally on out_ready or flush.
REQ-016 push = in_valid & in_ready & ~flush; writes in_bus at the write pointer, pointer toggles.
REQ-017 pop = out_valid & out_ready & ~flush; read pointer toggles.
REQ-018 out_valid = (count != 0); out_bus = entry at the read pointer, else {NOP_INST, RESET_PC} when count == 0.
REQ-019 Latency: an entry pushed in cycle N is visible on out_bus with out_valid=1 in cycle N+1 at the earliest; no same-cycle bypass from in_bus to out_bus.
REQ-020 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-021 Full (count=2): in_ready=0; in_valid is ignored even if pop occurs the same cycle; the push is retried next cycle by IF.
REQ-022 Empty (count=0): out_ready is ignored; no pop; count does not underflow.
REQ-023 Flush: next cycle count=0 and both pointers=0; a push and a pop offered in the flush cycle are both discarded.
REQ-024 flush_count increments by 1 in a flush cycle when count != 0 or in_valid=1; holds at 8'hFF once saturated.
REQ-025 Storage contents are not cleared on flush; only pointers and count are cleared.
REQ-026 occupancy = count, registered.

Reset
REQ-027 reset=1 at posedge: count=0, pointers=0, flush_count=0; in the following cycle in_ready=1, out_valid=0, out_bus={NOP_INST, RESET_PC}, occupancy=0.
REQ-028 reset has priority over flush, push and pop; reset asserted mid-operation discards all entries and does not increment flush_count.
REQ-029 Storage array requires no reset.

Verification
REQ-030 Single pass: push {32'h24080001, 32'hbfc00000} with out_ready=1 -> next cycle out_valid=1, out_bus matches, occupancy=1; following cycle occupancy=0.
REQ-031 Backpressure fill: out_ready=0, push PCs bfc00000, bfc00004, bfc00008 on consecutive cycles -> after two pushes occupancy=2 and in_ready=0; third entry not stored; release out_ready -> bfc00000 then bfc00004 delivered in order.
REQ-032 Full with simultaneous pop: count=2, in_valid=1, out_ready=1 -> head pops, in_ready was 0 so the new entry is not stored; occupancy=1 next cycle, in_ready=1.
REQ-033 Steady stream: in_valid=1 and out_ready=1 every cycle for 10 cycles, PCs incrementing by 4 -> occupancy stays at 1 after the first cycle; all 10 PCs emerge in order with 1-cycle latency.
REQ-034 Flush: occupancy=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_bus={NOP_INST, RESET_PC}, flush_count=1; a flush with count=0 and in_valid=0 leaves flush_count unchanged; 300 qualifying flushes -> flush_count=8'hFF.
REQ-035 Reset mid-stream: occupancy=2, flush_count=5, reset=1 together with flush=1 -> next cycle occupancy=0, flush_count=0, in_ready=1, out_valid=0.
